// File: rtl/fpu_sig_multiplier16.sv
// Radix-2 shift-add multiplier for FP16 significands (implicit bit included).
// Ports: clock, reset (sync, active-low), start, mulIn1/mulIn2 -> mulOut, done, busy.
module fpu_sig_multiplier16 #(
  parameter int WIDTH = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mulIn1,
  input  logic [WIDTH-1:0]   mulIn2,
  output logic [2*WIDTH-1:0] mulOut,
  output logic               done,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             last;
  logic             load;

  // Partial-sum kept at WIDTH+1 bits so the carry shifts into acc_hi.
  assign sum  = {1'b0, acc_hi}
              + (mplr[0] ? {1'b0, mcand} : '0);
  assign last = (cnt == CW'(WIDTH - 1));
  assign load = start
              && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = BUSY;
      BUSY: if (last)  state_nx = DONE;
      DONE: if (start) state_nx = BUSY;
      default:         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mcand  <= '0;
      mplr   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mulIn1;
      mplr   <= mulIn2;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc_hi <= sum[WIDTH:1];
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      mplr   <= mplr >> 1;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  assign busy   = (state == BUSY);
  assign done   = (state == DONE);
  // Partial sums never leak to the normalizer.
  assign mulOut = done ? {acc_hi, acc_lo} : '0;

endmodule
